// File: rtl/ctl_pkg.sv
// Shared types and constants for the stopwatch control FSM.
package ctl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'b00;
    localparam state_t ST_COUNTING = 2'b01;
    localparam state_t ST_PAUSED   = 2'b10;

    typedef struct packed {
        logic init_regs;
        logic count_enabled;
    } out_pat_t;

    localparam out_pat_t OUT_IDLE     = 2'b10;
    localparam out_pat_t OUT_COUNTING = 2'b01;
    localparam out_pat_t OUT_PAUSED   = 2'b00;

    // Moore decode; the unused code shows IDLE outputs until it recovers.
    function automatic out_pat_t decode_state(input state_t s);
        case (s)
            ST_COUNTING: decode_state = OUT_COUNTING;
            ST_PAUSED:   decode_state = OUT_PAUSED;
            default:     decode_state = OUT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ctl_if.sv
// Command/status bundle between the button stage, the FSM and the datapath.
interface ctl_if;
    logic trig;
    logic split;
    logic init_regs;
    logic count_enabled;

    modport master (output trig, output split, input init_regs, input count_enabled);
    modport slave  (input trig, input split, output init_regs, output count_enabled);
endinterface

// File: rtl/ctl.sv
// Stopwatch control FSM: turns trig/split pulses into datapath commands.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | counters held at zero, waiting for trig
//   COUNTING | counters advancing
//   PAUSED   | counters frozen; trig resumes, split clears
//   (2'b11)  | unused, IDLE outputs, returns to IDLE next edge
module ctl
    import ctl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    ctl_if.slave bus
);

    state_t   state_q;
    state_t   state_d;
    out_pat_t out_pat;

    // State register; reset low forces IDLE immediately and holds it there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; trig has priority over split in PAUSED.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                state_d = bus.trig ? ST_COUNTING : ST_IDLE;
            end
            ST_COUNTING: begin
                state_d = bus.trig ? ST_PAUSED : ST_COUNTING;
            end
            ST_PAUSED: begin
                if (bus.trig) begin
                    state_d = ST_COUNTING;
                end else if (bus.split) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode only the state register, so no input reaches them combinationally.
    always_comb begin
        out_pat = decode_state(state_q);
    end

    assign bus.init_regs     = out_pat.init_regs;
    assign bus.count_enabled = out_pat.count_enabled;

    // Clearing and counting must never be commanded together.
    a_outputs_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(bus.init_regs && bus.count_enabled));

endmodule

// File: tb/tb_ctl.sv
// Randomized self-checking bench for the stopwatch control FSM.
module tb_ctl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    // Reference model: the stopwatch is either cleared, running, or neither (paused).
    bit   m_cleared;
    bit   m_running;

    ctl_if bus ();

    ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: init/count got %b, expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_out();
        return {m_cleared, m_running};
    endfunction

    task automatic model_edge(input bit t, input bit s);
        if (t) begin
            // trig always starts or stops; from cleared it starts.
            m_running = m_cleared ? 1'b1 : !m_running;
            m_cleared = 1'b0;
        end else if (s && !m_running && !m_cleared) begin
            m_cleared = 1'b1;
        end
    endtask

    // One clock: apply inputs, take the edge, check #1 after it.
    task automatic step(input string tag, input bit t, input bit s);
        bus.trig  = t;
        bus.split = s;
        @(posedge clk);
        if (reset) model_edge(t, s);
        #1;
        bus.trig  = 1'b0;
        bus.split = 1'b0;
        chk(tag, {bus.init_regs, bus.count_enabled}, model_out());
    endtask

    // Drop reset between edges and check the outputs react before any edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        m_cleared = 1'b1;
        m_running = 1'b0;
        #1;
        chk(tag, {bus.init_regs, bus.count_enabled}, 2'b10);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.trig  = 1'b0;
        bus.split = 1'b0;
        reset     = 1'b0;
        m_cleared = 1'b1;
        m_running = 1'b0;

        // Reset held, then released; idle with no inputs.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", {bus.init_regs, bus.count_enabled}, 2'b10);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step("idle_quiet", 1'b0, 1'b0);

        // Start, split ignored while counting.
        step("start", 1'b1, 1'b0);
        chk("start_abs", {bus.init_regs, bus.count_enabled}, 2'b01);
        step("split_counting", 1'b0, 1'b1);
        chk("split_counting_abs", {bus.init_regs, bus.count_enabled}, 2'b01);

        // Pause and resume.
        step("pause", 1'b1, 1'b0);
        chk("pause_abs", {bus.init_regs, bus.count_enabled}, 2'b00);
        step("resume", 1'b1, 1'b0);
        chk("resume_abs", {bus.init_regs, bus.count_enabled}, 2'b01);

        // Async reset mid-count; trig under reset ignored; stays idle after release.
        async_reset("async_mid_count");
        step("trig_in_reset", 1'b1, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step("idle_after_release", 1'b0, 1'b0);
        chk("idle_after_release_abs", {bus.init_regs, bus.count_enabled}, 2'b10);

        // Paused then split clears.
        step("to_count", 1'b1, 1'b0);
        step("to_pause", 1'b1, 1'b0);
        step("split_clear", 1'b0, 1'b1);
        chk("split_clear_abs", {bus.init_regs, bus.count_enabled}, 2'b10);

        // trig beats split in PAUSED; held trig alternates.
        step("to_count2", 1'b1, 1'b0);
        step("to_pause2", 1'b1, 1'b0);
        step("trig_split", 1'b1, 1'b1);
        chk("trig_split_abs", {bus.init_regs, bus.count_enabled}, 2'b01);
        for (int i = 0; i < 4; i++) begin
            step("trig_held", 1'b1, 1'b0);
            chk("trig_held_abs", {bus.init_regs, bus.count_enabled},
                (i % 2 == 0) ? 2'b00 : 2'b01);
        end

        // First edge after reset release already acts on trig.
        async_reset("async_before_release");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("trig_first_edge", 1'b1, 1'b0);
        chk("trig_first_edge_abs", {bus.init_regs, bus.count_enabled}, 2'b01);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rand_async");
                step("rand_in_reset", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                reset = 1'b1;
            end else begin
                step("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
